// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: sequencer states and default timing constants.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int CLK_REF_HZ        = 50_000_000;
  localparam int POR_CYCLES_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF  = 50_000;     // 1 ms at CLK_REF_HZ
  localparam int STABLE_CYCLES_DEF = 1024;

  // Largest of three cycle counts; sizes the shared state counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous input, then re-register to settle metastability.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock and
// releases the system reset only after lock has been stable long enough.
// o_dbg_state mirrors the state register for observation.
module pll_lock_sequencer
  import clk_rst_pkg::*;
#(
  parameter int POR_CYCLES    = POR_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       fault,
  output pll_state_e o_dbg_state
);

  localparam int CNT_W = $clog2(max3(POR_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       FAULT_LEVEL = 4'(MAX_RETRIES);

  pll_state_e       r_state;
  pll_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_retry_inc;
  logic [3:0]       r_retry;
  logic [3:0]       w_retry_next;
  logic             r_fault;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             w_locked_s;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Next-state, counter and retry-count decisions; only the synchronized lock is used.
  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == POR_LAST) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (w_locked_s) begin
          w_next = STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next      = PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      STABLE: begin
        // A drop here is not a retry: the timeout window simply restarts.
        if (!w_locked_s) begin
          w_next = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next      = PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      default: w_next = PLL_RST;
    endcase

    w_cnt_next = (w_next != r_state) ? '0 : r_cnt + 1'b1;

    w_retry_next = r_retry;
    if (w_retry_inc && (r_retry != 4'hF)) w_retry_next = r_retry + 4'd1;
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PLL_RST;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_retry   <= 4'd0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_pll_rst <= (w_next == PLL_RST);
      r_sys_rst <= (w_next != RUN);
      r_ready   <= (w_next == RUN);
      r_retry   <= w_retry_next;
      r_fault   <= r_fault | (w_retry_next >= FAULT_LEVEL);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign retry_cnt   = r_retry;
  assign fault       = r_fault;
  assign o_dbg_state = r_state;

endmodule
